cordic_iter_engine: RTL

- Folded, iterative CORDIC engine: a single add/shift datapath performs N_ITER micro-rotations over successive cycles.
- Runtime-selectable rotation mode (drive z to 0) or vectoring mode (drive y to 0).
- Valid/ready handshake on both input and output sides.
- Arctangent constants come from an external table indexed by iter_o, so one engine serves every datapath width. Successor to the fixed per-stage pipeline slice.

---
 rtl/cordic_iter_engine.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/cordic_iter_engine.sv
// Folded iterative CORDIC engine: one shift/add datapath performs N_ITER
// micro-rotations over successive cycles, in rotation or vectoring mode.
// Arctangent constants come from an external table addressed by iter_o.
// Optional build macro: CORDIC_GAIN_COMP_EN adds a SCALE cycle that
// multiplies x and y by 1/K so the result carries no CORDIC gain.
module cordic_iter_engine #(
  parameter int N_FRAC         = 15,
  parameter int N_ITER         = 14,
  parameter int BW_SHIFT_VALUE = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      mode_i,
  input  logic signed [N_FRAC:0]    x_i,
  input  logic signed [N_FRAC:0]    y_i,
  input  logic signed [N_FRAC:0]    z_i,
  output logic [BW_SHIFT_VALUE-1:0] iter_o,
  input  logic signed [N_FRAC:0]    angle_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [N_FRAC:0]    x_o,
  output logic signed [N_FRAC:0]    y_o,
  output logic signed [N_FRAC:0]    z_o
);

  // Port width and internal width (two guard bits absorb the ~1.65 gain).
  localparam int DW = N_FRAC + 1;
  localparam int IW = N_FRAC + 3;

  localparam logic [BW_SHIFT_VALUE-1:0] ITER_LAST = BW_SHIFT_VALUE'(N_ITER - 1);

  localparam logic signed [IW-1:0] SAT_MAX = {3'b000, {N_FRAC{1'b1}}};
  localparam logic signed [IW-1:0] SAT_MIN = {3'b111, {N_FRAC{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
`ifdef CORDIC_GAIN_COMP_EN
    ST_SCALE,
`endif
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [BW_SHIFT_VALUE-1:0] iter_reg, iter_next;
  logic                      mode_reg, mode_next;
  logic signed [IW-1:0]      x_reg, x_next;
  logic signed [IW-1:0]      y_reg, y_next;
  logic signed [DW-1:0]      z_reg, z_next;
  logic signed [DW-1:0]      xo_reg, xo_next;
  logic signed [DW-1:0]      yo_reg, yo_next;
  logic signed [DW-1:0]      zo_reg, zo_next;

  // One micro-rotation computed from the current working registers.
  logic                 d_pos;
  logic signed [IW-1:0] x_sh, y_sh;
  logic signed [IW-1:0] x_rot, y_rot;
  logic signed [DW-1:0] z_rot;

  // Lane 0 is x, lane 1 is y: the values that get clamped into x_o/y_o.
  logic signed [IW-1:0] sat_in  [2];
  logic signed [DW-1:0] sat_out [2];

  function automatic logic signed [DW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end else begin
      return v[DW-1:0];
    end
  endfunction

  // Rotation/vectoring direction and shifted cross terms.
  always_comb begin
    d_pos = mode_reg ? y_reg[IW-1] : ~z_reg[DW-1];
    x_sh  = x_reg >>> iter_reg;
    y_sh  = y_reg >>> iter_reg;
    x_rot = d_pos ? (x_reg - y_sh) : (x_reg + y_sh);
    y_rot = d_pos ? (y_reg + x_sh) : (y_reg - x_sh);
    z_rot = d_pos ? (z_reg - angle_i) : (z_reg + angle_i);
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int              K_GAIN = int'(0.607252935 * (2.0 ** N_FRAC));
  localparam logic [DW-1:0]   K_VEC  = DW'(K_GAIN);

  logic signed [IW+DW-1:0] prod_x, prod_y;
  logic signed [IW-1:0]    x_scaled, y_scaled;

  // Gain compensation: multiply by 1/K in Q(N_FRAC), arithmetic shift back.
  always_comb begin
    prod_x   = $signed({{DW{x_reg[IW-1]}}, x_reg}) * $signed({{IW{1'b0}}, K_VEC});
    prod_y   = $signed({{DW{y_reg[IW-1]}}, y_reg}) * $signed({{IW{1'b0}}, K_VEC});
    x_scaled = prod_x[N_FRAC +: IW];
    y_scaled = prod_y[N_FRAC +: IW];
  end

  // Results are captured from the scaled values at the end of SCALE.
  always_comb begin
    sat_in[0] = x_scaled;
    sat_in[1] = y_scaled;
  end
`else
  // Results are captured from the final micro-rotation.
  always_comb begin
    sat_in[0] = x_rot;
    sat_in[1] = y_rot;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sat_lane
      assign sat_out[gi] = sat(sat_in[gi]);
    end
  endgenerate

  // Next-state and datapath update logic.
  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    mode_next  = mode_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    xo_next    = xo_reg;
    yo_next    = yo_reg;
    zo_next    = zo_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid_i) begin
          x_next     = {{2{x_i[DW-1]}}, x_i};
          y_next     = {{2{y_i[DW-1]}}, y_i};
          z_next     = z_i;
          mode_next  = mode_i;
          iter_next  = '0;
          state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        x_next = x_rot;
        y_next = y_rot;
        z_next = z_rot;
        if (iter_reg == ITER_LAST) begin
          // iter returns to 0 so iter_o reads 0 outside RUN.
          iter_next = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_next = ST_SCALE;
`else
          xo_next    = sat_out[0];
          yo_next    = sat_out[1];
          zo_next    = z_rot;
          state_next = ST_DONE;
`endif
        end else begin
          iter_next = iter_reg + BW_SHIFT_VALUE'(1);
        end
      end

`ifdef CORDIC_GAIN_COMP_EN
      ST_SCALE: begin
        x_next     = x_scaled;
        y_next     = y_scaled;
        xo_next    = sat_out[0];
        yo_next    = sat_out[1];
        zo_next    = z_reg;
        state_next = ST_DONE;
      end
`endif

      ST_DONE: begin
        if (out_ready_i) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset discards any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Working registers and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iter_reg <= '0;
      mode_reg <= 1'b0;
      x_reg    <= '0;
      y_reg    <= '0;
      z_reg    <= '0;
      xo_reg   <= '0;
      yo_reg   <= '0;
      zo_reg   <= '0;
    end else begin
      iter_reg <= iter_next;
      mode_reg <= mode_next;
      x_reg    <= x_next;
      y_reg    <= y_next;
      z_reg    <= z_next;
      xo_reg   <= xo_next;
      yo_reg   <= yo_next;
      zo_reg   <= zo_next;
    end
  end

  assign in_ready_o  = (state_reg == ST_IDLE);
  assign out_valid_o = (state_reg == ST_DONE);
  assign iter_o      = iter_reg;
  assign x_o         = xo_reg;
  assign y_o         = yo_reg;
  assign z_o         = zo_reg;

endmodule
